// File: rtl/wb_port_arbiter_if.sv
// Writeback-port arbiter bus bundle.
// Groups the three writeback request channels, the scoreboard issue/check
// signals and the registered regfile write port.
//   master : the sources and consumers around the arbiter (pipeline, mul/div,
//            load-return, decode, regfile)
//   slave  : the arbiter itself
interface wb_port_arbiter_if;
  // Pipeline WB stage
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        p_stall;
  // Mul/div result
  logic        m_valid;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_ready;
  // Load return
  logic        l_valid;
  logic [4:0]  l_waddr;
  logic [31:0] l_wdata;
  logic        l_ready;
  // Scoreboard
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [31:0] busy_vec;
  // Regfile write port
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output p_we, p_waddr, p_wdata,
    output m_valid, m_waddr, m_wdata,
    output l_valid, l_waddr, l_wdata,
    output iss_valid, iss_addr, chk_addr1, chk_addr2,
    input  p_stall, m_ready, l_ready,
    input  chk_busy1, chk_busy2, busy_vec,
    input  we, waddr, wdata
  );

  modport slave (
    input  p_we, p_waddr, p_wdata,
    input  m_valid, m_waddr, m_wdata,
    input  l_valid, l_waddr, l_wdata,
    input  iss_valid, iss_addr, chk_addr1, chk_addr2,
    output p_stall, m_ready, l_ready,
    output chk_busy1, chk_busy2, busy_vec,
    output we, waddr, wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter with pending-write scoreboard.
// Shares the single regfile write port among the pipeline WB stage, the
// mul/div unit and the load-return path. The pipeline has priority; the two
// secondaries alternate round-robin when both wait. The granted write is
// registered onto we/waddr/wdata one cycle later. A 32-entry scoreboard tracks
// destinations of issued long-latency ops until their secondary write lands.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (requests, handshakes, scoreboard,
//                regfile write port)
// Optional feature macro: WB_ARB_STARVE_GUARD_EN -- after STARVE_LIMIT
// consecutive pipeline wins with a secondary waiting, the pipeline is stalled
// for one cycle so a secondary can drain. Undefined: the pipeline always wins.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);

  if ((1 << CNT_W) <= STARVE_LIMIT) begin : g_bad_cfg
    $error("CNT_W too narrow for STARVE_LIMIT");
  end

  typedef enum logic [1:0] {SrcNone, SrcPipe, SrcMul, SrcLoad} src_e;

  src_e        src;
  logic        sec_req;
  logic        starve_hit;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;
  // 1: mul/div wins the next tie between the secondaries
  logic        rr_m_q, rr_m_d;

  assign sec_req = bus.m_valid | bus.l_valid;

`ifdef WB_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign starve_hit = rst_n && (cnt_q == CNT_W'(STARVE_LIMIT)) && sec_req;
  // Only consecutive pipeline wins over a waiting secondary count.
  assign cnt_d = (src == SrcPipe && sec_req) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Grant selection; nothing is granted while in reset.
  always_comb begin
    src = SrcNone;
    if (rst_n) begin
      if (bus.p_we && !starve_hit) begin
        src = SrcPipe;
      end else if (bus.m_valid && (!bus.l_valid || rr_m_q)) begin
        src = SrcMul;
      end else if (bus.l_valid) begin
        src = SrcLoad;
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    unique case (src)
      SrcPipe: begin
        gnt_addr = bus.p_waddr;
        gnt_data = bus.p_wdata;
      end
      SrcMul: begin
        gnt_addr = bus.m_waddr;
        gnt_data = bus.m_wdata;
      end
      SrcLoad: begin
        gnt_addr = bus.l_waddr;
        gnt_data = bus.l_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rr_m_d  = rr_m_q;
    busy_d  = busy_q;
    if (src != SrcNone) begin
      // Address-0 grants are consumed but never reach the regfile.
      we_d    = (gnt_addr != 5'd0);
      waddr_d = gnt_addr;
      wdata_d = gnt_data;
    end
    if (src == SrcMul) begin
      rr_m_d = 1'b0;
    end else if (src == SrcLoad) begin
      rr_m_d = 1'b1;
    end
    if (src == SrcMul || src == SrcLoad) begin
      busy_d[gnt_addr] = 1'b0;
    end
    // Set after clear so a same-cycle reissue keeps the register busy.
    if (bus.iss_valid) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      rr_m_q  <= 1'b1;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      rr_m_q  <= rr_m_d;
    end
  end

  assign bus.p_stall   = starve_hit;
  assign bus.m_ready   = (src == SrcMul);
  assign bus.l_ready   = (src == SrcLoad);
  assign bus.we        = we_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.busy_vec  = busy_q;
  // busy_q[0] is held at 0, so register 0 never reads busy.
  assign bus.chk_busy1 = busy_q[bus.chk_addr1];
  assign bus.chk_busy2 = busy_q[bus.chk_addr2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed stimulus, a reference model of the
// arbitration/scoreboard rules checked every cycle, and hand-computed pins.
module tb_wb_port_arbiter;

  localparam int unsigned Limit = 8;
`ifdef WB_ARB_STARVE_GUARD_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  localparam int SelWe = 0, SelWaddr = 1, SelWdata = 2, SelBusy = 3, SelMr = 4,
                 SelLr = 5, SelStall = 6, SelCb1 = 7, SelCb2 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .STARVE_LIMIT(Limit),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Hand-computed expectations, consumed by the compare process.
  string       pin_name [64];
  int          pin_sel  [64];
  logic [31:0] pin_exp  [64];
  int          pin_wr = 0;
  int          pin_rd = 0;
  event        chk_ev;

  // Reference model state and its next value.
  logic        mdl_we, nxt_we;
  logic [4:0]  mdl_waddr, nxt_waddr;
  logic [31:0] mdl_wdata, nxt_wdata;
  logic [31:0] mdl_busy, nxt_busy;
  logic        mdl_fav_m, nxt_fav_m;
  int          mdl_starve, nxt_starve;

  function automatic logic [31:0] dut_sig(input int sel);
    case (sel)
      SelWe:    return {31'b0, bus.we};
      SelWaddr: return {27'b0, bus.waddr};
      SelWdata: return bus.wdata;
      SelBusy:  return bus.busy_vec;
      SelMr:    return {31'b0, bus.m_ready};
      SelLr:    return {31'b0, bus.l_ready};
      SelStall: return {31'b0, bus.p_stall};
      SelCb1:   return {31'b0, bus.chk_busy1};
      default:  return {31'b0, bus.chk_busy2};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_we     <= 1'b0;
      mdl_waddr  <= '0;
      mdl_wdata  <= '0;
      mdl_busy   <= '0;
      mdl_fav_m  <= 1'b1;
      mdl_starve <= 0;
    end else begin
      mdl_we     <= nxt_we;
      mdl_waddr  <= nxt_waddr;
      mdl_wdata  <= nxt_wdata;
      mdl_busy   <= nxt_busy;
      mdl_fav_m  <= nxt_fav_m;
      mdl_starve <= nxt_starve;
    end
  end

  // Compare process: pins first, then the full model check.
  always begin : compare
    int          winner;  // 0 none, 1 pipeline, 2 mul/div, 3 load
    logic        stall;
    logic        waiting;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk or chk_ev);
    while (pin_rd < pin_wr) begin
      check(pin_name[pin_rd], dut_sig(pin_sel[pin_rd]), pin_exp[pin_rd]);
      pin_rd++;
    end
    waiting = bus.m_valid || bus.l_valid;
    stall   = StarveEn && rst_n && (mdl_starve == int'(Limit)) && waiting;
    winner  = 0;
    a       = '0;
    d       = '0;
    if (rst_n) begin
      if (bus.p_we && !stall) winner = 1;
      else if (bus.m_valid && bus.l_valid) winner = mdl_fav_m ? 2 : 3;
      else if (bus.m_valid) winner = 2;
      else if (bus.l_valid) winner = 3;
    end
    if (winner == 1) begin a = bus.p_waddr; d = bus.p_wdata; end
    if (winner == 2) begin a = bus.m_waddr; d = bus.m_wdata; end
    if (winner == 3) begin a = bus.l_waddr; d = bus.l_wdata; end

    check("model_we", {31'b0, bus.we}, {31'b0, mdl_we});
    check("model_waddr", {27'b0, bus.waddr}, {27'b0, mdl_waddr});
    check("model_wdata", bus.wdata, mdl_wdata);
    check("model_busy_vec", bus.busy_vec, mdl_busy);
    check("model_m_ready", {31'b0, bus.m_ready}, (winner == 2) ? 32'd1 : 32'd0);
    check("model_l_ready", {31'b0, bus.l_ready}, (winner == 3) ? 32'd1 : 32'd0);
    check("model_p_stall", {31'b0, bus.p_stall}, {31'b0, stall});
    check("model_chk_busy1", {31'b0, bus.chk_busy1},
          {31'b0, (bus.chk_addr1 != 0) && mdl_busy[bus.chk_addr1]});
    check("model_chk_busy2", {31'b0, bus.chk_busy2},
          {31'b0, (bus.chk_addr2 != 0) && mdl_busy[bus.chk_addr2]});

    if (!rst_n) begin
      nxt_we = 1'b0; nxt_waddr = '0; nxt_wdata = '0;
      nxt_busy = '0; nxt_fav_m = 1'b1; nxt_starve = 0;
    end else begin
      nxt_we     = (winner != 0) && (a != 0);
      nxt_waddr  = (winner != 0) ? a : mdl_waddr;
      nxt_wdata  = (winner != 0) ? d : mdl_wdata;
      nxt_busy   = mdl_busy;
      nxt_fav_m  = (winner == 2) ? 1'b0 : (winner == 3) ? 1'b1 : mdl_fav_m;
      nxt_starve = (StarveEn && winner == 1 && waiting) ? mdl_starve + 1 : 0;
      if (winner >= 2 && a != 0) nxt_busy[a] = 1'b0;
      if (bus.iss_valid && bus.iss_addr != 0) nxt_busy[bus.iss_addr] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int sel, input logic [31:0] exp);
    pin_name[pin_wr] = name;
    pin_sel[pin_wr]  = sel;
    pin_exp[pin_wr]  = exp;
    pin_wr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.p_we = 0; bus.p_waddr = 0; bus.p_wdata = 0;
    bus.m_valid = 0; bus.m_waddr = 0; bus.m_wdata = 0;
    bus.l_valid = 0; bus.l_waddr = 0; bus.l_wdata = 0;
    bus.iss_valid = 0; bus.iss_addr = 0;
    bus.chk_addr1 = 0; bus.chk_addr2 = 0;
  endtask

  initial begin
    set_idle();
    // Requests during reset must see no handshakes.
    bus.p_we = 1; bus.m_valid = 1; bus.l_valid = 1;
    tick();
    pin("rst_m_ready", SelMr, 0);
    pin("rst_l_ready", SelLr, 0);
    pin("rst_p_stall", SelStall, 0);
    pin("rst_we", SelWe, 0);
    pin("rst_busy", SelBusy, 0);
    tick();
    set_idle();
    rst_n = 1;

    // Pipeline write lands one cycle later.
    tick();
    bus.p_we = 1; bus.p_waddr = 5; bus.p_wdata = 32'h1234;
    tick();
    bus.p_we = 0;
    pin("p_we", SelWe, 1);
    pin("p_waddr", SelWaddr, 5);
    pin("p_wdata", SelWdata, 32'h1234);

    // Scoreboard set, then m/l round-robin with m favoured first.
    bus.iss_valid = 1; bus.iss_addr = 7; bus.chk_addr1 = 7;
    tick();
    bus.iss_valid = 0;
    pin("busy7_set", SelBusy, 32'h80);
    pin("chk_busy1_7", SelCb1, 1);
    bus.m_valid = 1; bus.m_waddr = 7; bus.m_wdata = 32'hAAAA;
    bus.l_valid = 1; bus.l_waddr = 9; bus.l_wdata = 32'hBBBB;
    pin("rr_m_first", SelMr, 1);
    pin("rr_l_waits", SelLr, 0);
    tick();
    bus.m_valid = 0;
    pin("rr_l_second", SelLr, 1);
    pin("m_write_we", SelWe, 1);
    pin("m_write_addr", SelWaddr, 7);
    pin("m_write_data", SelWdata, 32'hAAAA);
    pin("busy7_clear", SelBusy, 0);
    tick();
    bus.l_valid = 0;
    pin("l_write_addr", SelWaddr, 9);
    pin("l_write_data", SelWdata, 32'hBBBB);
    tick();
    pin("idle_we", SelWe, 0);
    pin("idle_waddr_hold", SelWaddr, 9);

    // Same-cycle set and clear of r3: set wins.
    bus.m_valid = 1; bus.m_waddr = 3; bus.m_wdata = 32'h33;
    bus.iss_valid = 1; bus.iss_addr = 3; bus.chk_addr2 = 3;
    tick();
    bus.m_valid = 0; bus.iss_valid = 0;
    pin("set_wins_busy", SelBusy, 32'h8);
    pin("chk_busy2_3", SelCb2, 1);
    bus.l_valid = 1; bus.l_waddr = 3; bus.l_wdata = 32'h44;
    pin("l_ready_3", SelLr, 1);
    tick();
    bus.l_valid = 0;
    pin("busy3_clear", SelBusy, 0);
    bus.iss_valid = 1; bus.iss_addr = 0;
    tick();
    bus.iss_valid = 0;
    pin("iss_r0_ignored", SelBusy, 0);

    // Load to r0 is consumed without a write.
    bus.l_valid = 1; bus.l_waddr = 0; bus.l_wdata = 32'h55;
    pin("l_ready_r0", SelLr, 1);
    tick();
    bus.l_valid = 0;
    pin("r0_no_we", SelWe, 0);

    // Pipeline streaming against a waiting mul/div result.
    for (int i = 1; i <= 12; i++) begin
      tick();
      bus.p_we = 1; bus.p_waddr = 4; bus.p_wdata = 32'h4444;
      bus.m_valid = (StarveEn && i >= 10) ? 1'b0 : 1'b1;
      bus.m_waddr = 6; bus.m_wdata = 32'h6666;
      pin("starve_stall", SelStall, (StarveEn && i == 9) ? 32'd1 : 32'd0);
      pin("starve_m_ready", SelMr, (StarveEn && i == 9) ? 32'd1 : 32'd0);
    end
    tick();
    bus.p_we = 0;
    pin("drain_m_ready", SelMr, StarveEn ? 32'd0 : 32'd1);
    tick();
    bus.m_valid = 0;
    pin("drain_we", SelWe, StarveEn ? 32'd0 : 32'd1);

    // Asynchronous reset in the middle of traffic.
    bus.iss_valid = 1; bus.iss_addr = 7;
    bus.p_we = 1; bus.p_waddr = 2; bus.p_wdata = 32'h22;
    bus.m_valid = 1; bus.m_waddr = 8; bus.m_wdata = 32'h88;
    tick();
    bus.iss_valid = 0; bus.p_we = 0;
    pin("pre_rst_we", SelWe, 1);
    pin("pre_rst_busy", SelBusy, 32'h80);
    pin("pre_rst_m_ready", SelMr, 1);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    pin("async_rst_busy", SelBusy, 0);
    pin("async_rst_we", SelWe, 0);
    pin("async_rst_m_ready", SelMr, 0);
    -> chk_ev;
    #1;
    tick();
    set_idle();
    tick();
    rst_n = 1;
    tick();
    pin("post_rst_we", SelWe, 0);
    bus.m_valid = 1; bus.m_waddr = 8; bus.m_wdata = 32'h88;
    pin("re_present_m_ready", SelMr, 1);
    tick();
    bus.m_valid = 0;
    pin("re_present_addr", SelWaddr, 8);
    pin("re_present_data", SelWdata, 32'h88);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
